// File: rtl/icdf_pkg.sv
// Shared types, constants and segment/residual derivation for the ICDF sequencer.
// The derivation function returns the residual left-aligned at bit 30 so callers can slice any width.
package icdf_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } seq_state_t;

   localparam int         SEG_W   = 7;
   localparam logic [3:0] SAT_OCT = 4'd15;

   typedef struct packed {
      logic [SEG_W-1:0] seg;
      logic [30:0]      x_full;
   } seg_x_t;

   // Normalising by lz puts the leading one at bit 30; the three bits below it pick the
   // sub-segment and everything further down is the residual. Small magnitudes share one octave.
   function automatic seg_x_t derive_seg_x(input logic [30:0] m,
                                           input logic [4:0]  lz,
                                           input logic        sat);
      seg_x_t      r;
      logic [30:0] norm;
      norm = m << lz;
      if (sat) begin
         r.seg    = {SAT_OCT, m[15:13]};
         r.x_full = {m[12:0], 18'd0};
      end else begin
         r.seg    = {lz[3:0], norm[29:27]};
         r.x_full = {norm[26:0], 4'd0};
      end
      return r;
   endfunction

endpackage

// File: rtl/icdf_seg_lzc.sv
// 31-bit leading-zero counter plus the saturated-octave flag (no set bit above bit 15).
module icdf_seg_lzc (
   input  logic [30:0] m,
   output logic [4:0]  lz,
   output logic        sat
);

   // Scanning upward lets the highest set bit overwrite any lower one.
   always_comb begin
      lz = 5'd31;
      for (int i = 0; i < 31; i++) begin
         if (m[i]) lz = 5'(30 - i);
      end
   end

   assign sat = (m[30:16] == 15'd0);

endmodule

// File: rtl/icdf_seq_ctrl.sv
// Burst sequencer for the ICDF Gaussian front end: S1 word register drives the coefficient ROM,
// output register aligns x/sign with its registered coefficients. Optional macro: ICDF_SEQ_STATS_EN.
module icdf_seq_ctrl
   import icdf_pkg::*;
#(
   parameter int LEN_W = 16,
   parameter int X_W   = 18
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic [31:0]      u_data,
   input  logic             u_valid,
   output logic             u_ready,
   output logic [SEG_W-1:0] segment,
   output logic             en_coef,
   output logic [X_W-1:0]   x_out,
   output logic             sign_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             done
`ifdef ICDF_SEQ_STATS_EN
   ,
   output logic [LEN_W-1:0] sat_cnt
`endif
);

   seq_state_t       state, state_next;
   logic [LEN_W-1:0] remaining;
   logic [31:0]      s1_data;
   logic             s1_valid;
   logic             advance;
   logic             accept;
   logic             load_out;
   logic [4:0]       lz;
   logic             sat;
   seg_x_t           sx;
   logic [X_W+30:0]  x_pad;
   logic [X_W-1:0]   x_next;

   icdf_seg_lzc u_lzc (
      .m   (s1_data[30:0]),
      .lz  (lz),
      .sat (sat)
   );

   assign sx       = derive_seg_x(s1_data[30:0], lz, sat);
   assign x_pad    = {sx.x_full, X_W'(0)};
   assign x_next   = x_pad[X_W+30 -: X_W];
   assign advance  = ~out_valid | out_ready;
   assign accept   = u_valid & u_ready;
   assign load_out = advance & s1_valid;

   // Segment is forced to zero while S1 is empty so the ROM address idles at a known value.
   assign segment  = s1_valid ? sx.seg : '0;
   assign en_coef  = s1_valid;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = (len == '0) ? DONE : RUN;
         RUN:     if (accept && remaining == LEN_W'(1)) state_next = DRAIN;
         DRAIN:   if (!s1_valid && !out_valid) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy    = (state != IDLE);
      done    = (state == DONE);
      u_ready = (state == RUN) && (remaining != '0) && (!s1_valid || advance);
   end

   always_ff @(posedge clk) begin
      if (rst)                        remaining <= '0;
      else if (state == IDLE && start) remaining <= len;
      else if (accept)                remaining <= remaining - LEN_W'(1);
   end

   // S1 holds its word through a stall so segment, and therefore the ROM output, stays put.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_data  <= '0;
         s1_valid <= 1'b0;
      end else if (accept) begin
         s1_data  <= u_data;
         s1_valid <= 1'b1;
      end else if (advance) begin
         s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_out     <= '0;
         sign_out  <= 1'b0;
         out_valid <= 1'b0;
      end else if (load_out) begin
         x_out     <= x_next;
         sign_out  <= s1_data[31];
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef ICDF_SEQ_STATS_EN
   always_ff @(posedge clk) begin
      if (rst)                                  sat_cnt <= '0;
      else if (state == IDLE && start)           sat_cnt <= '0;
      else if (load_out && sat && sat_cnt != '1) sat_cnt <= sat_cnt + LEN_W'(1);
   end
`else
   // Without statistics there is no saturated-segment counter.
`endif

endmodule
